// File: rtl/data_mem_pkg.sv
// Shared encodings and defaults for the data memory controller.
package data_mem_pkg;
  localparam int DEF_WIDTH       = 64;
  localparam int DEF_DEPTH       = 32;
  localparam int DEF_WAIT_CYCLES = 1;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extract/extend, store byte merge, fault check.
module dmem_lane_align
  import data_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH * WIDTH / 8)
) (
  input  logic [1:0]       size,
  input  logic             is_signed,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] word,
  output logic             fault,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] merged
);
  localparam int OFFW = $clog2(WIDTH / 8);

  logic [OFFW+2:0]  sh;
  logic [WIDTH-1:0] shifted, szmask, lane_mask;
  logic             misal, sb, bad_size, bad_idx;

  assign sh = {addr[OFFW-1:0], 3'b000};

  always_comb begin
    shifted = word >> sh;
    szmask  = '1;
    misal   = 1'b0;
    sb      = shifted[WIDTH-1];
    case (size)
      SZ_BYTE: begin szmask = WIDTH'(8'hFF); sb = shifted[7]; end
      SZ_HALF: begin szmask = WIDTH'(16'hFFFF); misal = addr[0]; sb = shifted[15]; end
      SZ_WORD: begin szmask = WIDTH'(32'hFFFF_FFFF); misal = |addr[1:0]; sb = shifted[31]; end
      default: begin szmask = '1; misal = |addr[2:0]; sb = shifted[WIDTH-1]; end
    endcase
    bad_size  = (size == SZ_DOUBLE) && (WIDTH == 32);
    // Only reachable if the address is ever widened beyond the array.
    bad_idx   = int'(addr[AW-1:OFFW]) >= DEPTH;
    fault     = misal | bad_size | bad_idx;
    rdata     = (shifted & szmask) | ((is_signed && sb) ? ~szmask : '0);
    lane_mask = szmask << sh;
    merged    = (word & ~lane_mask) | ((wdata & szmask) << sh);
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with sized/sign-extended access and wait states.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  localparam int AW         = $clog2(DEPTH * WIDTH / 8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_error
);
  localparam int OFFW = $clog2(WIDTH / 8);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             wr_q, wr_d, sgn_q, sgn_d;
  logic [1:0]       size_q, size_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [WIDTH-1:0] mem [DEPTH];

  // With zero wait states the access completes on the acceptance edge,
  // so the live request fields are steered in while idle.
  logic             cur_wr, cur_sgn, go_resp, mem_we, fault;
  logic [1:0]       cur_size;
  logic [AW-1:0]    cur_addr;
  logic [WIDTH-1:0] cur_wdata, ld_data, st_word;

  assign req_ready = (state_q == IDLE);
  assign cur_wr    = req_ready ? req_write  : wr_q;
  assign cur_sgn   = req_ready ? req_signed : sgn_q;
  assign cur_size  = req_ready ? req_size   : size_q;
  assign cur_addr  = req_ready ? req_addr   : addr_q;
  assign cur_wdata = req_ready ? req_wdata  : wdata_q;

  dmem_lane_align #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_align (
    .size      (cur_size),
    .is_signed (cur_sgn),
    .addr      (cur_addr),
    .wdata     (cur_wdata),
    .word      (mem[cur_addr[AW-1:OFFW]]),
    .fault     (fault),
    .rdata     (ld_data),
    .merged    (st_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d    = req_write;
        sgn_d   = req_signed;
        size_d  = req_size;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (WAIT_CYCLES == 0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        go_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rsp_valid_d = go_resp;
    rsp_error_d = go_resp ? fault : rsp_error_q;
    rsp_rdata_d = go_resp ? ((cur_wr || fault) ? '0 : ld_data) : rsp_rdata_q;
    mem_we      = go_resp && cur_wr && !fault && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      sgn_q       <= sgn_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_addr[AW-1:OFFW]] <= st_word;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Random + directed bench for data_mem_ctrl against a byte-array reference model.
module tb_data_mem_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        rv64 = 1'b0, rv32 = 1'b0;
  logic        req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = '0;
  logic [7:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rdy64, rdy32, vld64, vld32, err64, err32;
  logic [63:0] rdata64;
  logic [31:0] rdata32;

  int errs = 0, checks = 0;
  logic [7:0] bmem [2][256];

  always #5 clk = ~clk;

  data_mem_ctrl #(.WIDTH(64), .DEPTH(32), .WAIT_CYCLES(2)) u_dut64 (
    .clk(clk), .reset(reset), .req_valid(rv64), .req_ready(rdy64),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld64), .rsp_rdata(rdata64), .rsp_error(err64));

  data_mem_ctrl #(.WIDTH(32), .DEPTH(32), .WAIT_CYCLES(0)) u_dut32 (
    .clk(clk), .reset(reset), .req_valid(rv32), .req_ready(rdy32),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr[6:0]), .req_wdata(req_wdata[31:0]),
    .rsp_valid(vld32), .rsp_rdata(rdata32), .rsp_error(err32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory, faults from size/alignment rules.
  task automatic model(input bit d32, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [7:0] a, input logic [63:0] wd,
                       output logic [63:0] exp, output bit fault);
    int nb = 1 << sz;
    int w  = d32 ? 4 : 8;
    fault = (int'(a) % nb) != 0 || (d32 && sz == 2'b11) || (int'(a) / w) >= 32;
    exp = '0;
    if (!fault) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) bmem[d32][int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) exp[8*i +: 8] = bmem[d32][int'(a) + i];
        if (sg && exp[8*nb-1])
          for (int i = nb; i < w; i++) exp[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic access(input bit d32, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [7:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output bit er);
    int lat;
    logic [63:0] exp;
    bit fault;
    @(negedge clk);
    for (int t = 0; t < 20 && !(d32 ? rdy32 : rdy64); t++) @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    if (d32) rv32 = 1'b1; else rv64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv32 = 1'b0; rv64 = 1'b0;
    lat = 1;
    while (!(d32 ? vld32 : vld64) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = d32 ? {32'h0, rdata32} : rdata64;
    er = d32 ? err32 : err64;
    model(d32, wr, sz, sg, a, wd, exp, fault);
    chk("latency", 64'(lat), d32 ? 64'd1 : 64'd3);
    chk("rdata", rd, exp);
    chk("error", 64'(er), 64'(fault));
    @(negedge clk);
    chk("pulse", 64'(d32 ? vld32 : vld64), 64'd0);
    chk("hold", d32 ? {32'h0, rdata32} : rdata64, rd);
  endtask

  initial begin
    logic [63:0] rd, exp;
    logic [1:0]  sz;
    logic [7:0]  a;
    bit er, d32, ft;
    int acc, last, nb;
    bit prev;

    repeat (3) @(negedge clk);
    chk("rst_vld64", 64'(vld64), 64'd0);
    chk("rst_rd64", rdata64, 64'd0);
    chk("rst_err64", 64'(err64), 64'd0);
    chk("rst_vld32", 64'(vld32), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy64", 64'(rdy64), 64'd1);
    chk("rst_rdy32", 64'(rdy32), 64'd1);

    for (int w = 0; w < 32; w++) access(0, 1, 2'b11, 0, 8'(8*w), {$urandom, $urandom}, rd, er);
    for (int w = 0; w < 32; w++) access(1, 1, 2'b10, 0, 8'(4*w), {32'h0, $urandom}, rd, er);

    access(0, 1, 2'b11, 0, 8'h08, 64'h1122334455667788, rd, er);
    access(0, 0, 2'b11, 0, 8'h08, 64'h0, rd, er);
    chk("dbl_ld", rd, 64'h1122334455667788);
    chk("dbl_err", 64'(er), 64'd0);
    access(0, 1, 2'b00, 0, 8'h0B, 64'hAB, rd, er);
    access(0, 0, 2'b00, 1, 8'h0B, 64'h0, rd, er);
    chk("sbyte_ld", rd, 64'hFFFFFFFFFFFFFFAB);
    access(0, 0, 2'b11, 0, 8'h08, 64'h0, rd, er);
    chk("merge_ld", rd, 64'h11223344AB667788);
    access(0, 0, 2'b01, 0, 8'h03, 64'h0, rd, er);
    chk("mis_half_err", 64'(er), 64'd1);
    chk("mis_half_rd", rd, 64'd0);
    access(0, 1, 2'b10, 0, 8'h05, 64'hDEADBEEF, rd, er);
    chk("mis_word_err", 64'(er), 64'd1);
    access(0, 0, 2'b11, 0, 8'h00, 64'h0, rd, er);
    access(1, 0, 2'b11, 0, 8'h00, 64'h0, rd, er);
    chk("w32_dbl_err", 64'(er), 64'd1);

    // Reset during WAIT of a store must abort it.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 8'h00; req_wdata = 64'hFF;
    rv64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv64 = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_vld_a", 64'(vld64), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_vld_b", 64'(vld64), 64'd0);
    chk("abort_rd", rdata64, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rdy", 64'(rdy64), 64'd1);
    access(0, 0, 2'b11, 0, 8'h00, 64'h0, rd, er);

    // Back-to-back loads with valid held high, zero wait states.
    model(1, 0, 2'b10, 0, 8'h04, 64'h0, exp, ft);
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'h04;
    rv32 = 1'b1;
    acc = 0; last = -1; prev = 1'b0;
    for (int c = 0; c < 14; c++) begin
      chk("b2b_vld", 64'(vld32), 64'(prev));
      if (vld32) chk("b2b_rd", {32'h0, rdata32}, exp);
      prev = rv32 && rdy32;
      if (prev) begin
        if (last >= 0) chk("b2b_gap", 64'(c - last), 64'd2);
        last = c;
        acc++;
      end
      @(negedge clk);
      if (acc == 4) rv32 = 1'b0;
    end
    chk("b2b_cnt", 64'(acc), 64'd4);

    for (int n = 0; n < 80; n++) begin
      d32 = 1'($urandom);
      sz  = 2'($urandom);
      nb  = 1 << sz;
      a   = 8'($urandom) & (d32 ? 8'h7F : 8'hFF);
      if ($urandom_range(3) != 0) a = a & ~8'(nb - 1);
      access(d32, 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
